// File: rtl/lbm_frame_scheduler_if.sv
// lbm_frame_scheduler_if: solver handshake and AXIS streamer signals between scheduler and datapath
//   solver_start   scheduler -> solver    1-cycle pulse that begins one iteration
//   solver_done    solver -> scheduler    1-cycle pulse when the iteration's writes are finished
//   solver_rd_bank scheduler -> solver    bank the solver reads
//   solver_wr_bank scheduler -> solver    bank the solver writes
//   stream_req     scheduler -> streamer  level request to stream stream_bank
//   stream_bank    scheduler -> streamer  bank the streamer reads
//   stream_tvalid  streamer (monitored)   AXIS tvalid
//   stream_tready  downstream (monitored) AXIS tready
//   stream_tlast   streamer (monitored)   AXIS tlast
interface lbm_frame_scheduler_if;
    logic solver_start;
    logic solver_done;
    logic solver_rd_bank;
    logic solver_wr_bank;
    logic stream_req;
    logic stream_bank;
    logic stream_tvalid;
    logic stream_tready;
    logic stream_tlast;
    modport master (
        output solver_start, solver_rd_bank, solver_wr_bank, stream_req, stream_bank,
        input  solver_done, stream_tvalid, stream_tready, stream_tlast
    );
    modport slave (
        input  solver_start, solver_rd_bank, solver_wr_bank, stream_req, stream_bank,
        output solver_done, stream_tvalid, stream_tready, stream_tlast
    );
endinterface

// File: rtl/lbm_frame_scheduler.sv
// lbm_frame_scheduler: runs LBM iterations over ping-pong banks and hands every Nth frame to the streamer
//   m00_axis_aclk, m00_axis_aresetn  clock and async active-low reset
//   start, cfg_num_iters, cfg_out_every  run request and its configuration (taken in IDLE)
//   bus            solver handshake, bank selects and streamer request/monitor signals
//   iter_count     completed iterations this run (saturating)
//   busy           high outside IDLE
//   run_done       1-cycle pulse at end of run
//   err_spurious   sticky flag for solver_done outside SOLVE, cleared by an accepted start
module lbm_frame_scheduler #(
    parameter int ITER_WIDTH   = 16,
    parameter bit INIT_RD_BANK = 1'b0
) (
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_aresetn,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] cfg_num_iters,
    input  logic [ITER_WIDTH-1:0] cfg_out_every,
    lbm_frame_scheduler_if.master bus,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  busy,
    output logic                  run_done,
    output logic                  err_spurious
);
    typedef enum logic [2:0] {IDLE, LAUNCH, SOLVE, POST, WAIT_STREAM, DRAIN} state_t;
    state_t state;
    logic [ITER_WIDTH-1:0] num_iters, out_every, phase, phase_dec;
    logic pending, cpl, active, due, remain;
    assign cpl       = bus.stream_req & bus.stream_tvalid & bus.stream_tready & bus.stream_tlast;
    // a completion in this cycle already frees the streamer for the decision being made now
    assign active    = bus.stream_req & ~cpl;
    assign phase_dec = phase - ITER_WIDTH'(1);
    assign due       = (out_every != '0) && (phase_dec == '0);
    assign remain    = iter_count < num_iters;
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state              <= IDLE;
            num_iters          <= '0;
            out_every          <= '0;
            phase              <= '0;
            pending            <= 1'b0;
            iter_count         <= '0;
            busy               <= 1'b0;
            run_done           <= 1'b0;
            err_spurious       <= 1'b0;
            bus.solver_start   <= 1'b0;
            bus.solver_rd_bank <= INIT_RD_BANK;
            bus.solver_wr_bank <= ~INIT_RD_BANK;
            bus.stream_req     <= 1'b0;
            bus.stream_bank    <= 1'b0;
        end else begin
            bus.solver_start <= 1'b0;
            run_done         <= 1'b0;
            if (cpl) bus.stream_req <= 1'b0;
            if (bus.solver_done && state != SOLVE) err_spurious <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    num_iters    <= cfg_num_iters;
                    out_every    <= cfg_out_every;
                    phase        <= cfg_out_every;
                    pending      <= 1'b0;
                    iter_count   <= '0;
                    err_spurious <= bus.solver_done;
                    busy         <= 1'b1;
                    if (cfg_num_iters == '0) state <= DRAIN;
                    else begin
                        state            <= LAUNCH;
                        bus.solver_start <= 1'b1;
                    end
                end
                LAUNCH: state <= SOLVE;
                // iteration bookkeeping is committed as SOLVE ends so POST already shows it
                SOLVE: if (bus.solver_done) begin
                    state              <= POST;
                    iter_count         <= iter_count + {{(ITER_WIDTH-1){1'b0}}, ~&iter_count};
                    bus.solver_rd_bank <= ~bus.solver_rd_bank;
                    bus.solver_wr_bank <= ~bus.solver_wr_bank;
                    phase              <= due ? out_every : phase_dec;
                    pending            <= due & active;
                    if (due && !active) begin
                        bus.stream_bank <= ~bus.solver_rd_bank;
                        bus.stream_req  <= 1'b1;
                    end
                end
                // POST and WAIT_STREAM share one decision; banks are already the post-iteration ones
                POST, WAIT_STREAM: begin
                    if (pending && active) state <= WAIT_STREAM;
                    else begin
                        if (pending) begin
                            bus.stream_bank <= bus.solver_rd_bank;
                            bus.stream_req  <= 1'b1;
                            pending         <= 1'b0;
                        end
                        if (!remain) state <= DRAIN;
                        else if (!pending && active && bus.solver_wr_bank == bus.stream_bank)
                            state <= WAIT_STREAM;
                        else begin
                            state            <= LAUNCH;
                            bus.solver_start <= 1'b1;
                        end
                    end
                end
                DRAIN: if (!bus.stream_req) begin
                    state    <= IDLE;
                    run_done <= 1'b1;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
